// File: rtl/prince_mask_pkg.sv
// Shared constants, layer FSM states and the unmasked PRINCE inverse S-box
// reference for the 3-share masked PRINCE datapath.
package prince_mask_pkg;
  localparam int unsigned NIBBLES    = 16;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned KLMN_IN1_W = 4;
  localparam int unsigned KLMN_IO_W  = 6;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} layer_state_e;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hB;  4'h1: y = 4'h7;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
      4'h4: y = 4'hF;  4'h5: y = 4'hD;  4'h6: y = 4'h8;  4'h7: y = 4'h9;
      4'h8: y = 4'hA;  4'h9: y = 4'h6;  4'hA: y = 4'h4;  4'hB: y = 4'h0;
      4'hC: y = 4'h5;  4'hD: y = 4'hE;  4'hE: y = 4'hC;  default: y = 4'h1;
    endcase
    return y;
  endfunction
endpackage

// File: rtl/prince_share_nibble_sel.sv
// Selects nibble idx from each of three 64-bit shares; each share is muxed
// independently so no two shares ever meet in the same logic cone.
module prince_share_nibble_sel
  import prince_mask_pkg::*;
(
  input  logic [63:0]      st1,
  input  logic [63:0]      st2,
  input  logic [63:0]      st3,
  input  logic [3:0]       idx,
  output logic [NIB_W-1:0] nib1,
  output logic [NIB_W-1:0] nib2,
  output logic [NIB_W-1:0] nib3
);
  assign nib1 = st1[idx*NIB_W +: NIB_W];
  assign nib2 = st2[idx*NIB_W +: NIB_W];
  assign nib3 = st3[idx*NIB_W +: NIB_W];
endmodule

// File: rtl/prince_sbox_inv_layer_ctrl.sv
// Nibble-serial controller for one masked inverse S-box layer: issues 16
// nibbles into the external S-box pipeline and reassembles its output shares.
module prince_sbox_inv_layer_ctrl
  import prince_mask_pkg::*;
#(
  parameter int unsigned SBOX_LAT = 4,
  parameter int unsigned RND_W    = 42
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [63:0]           st1_i,
  input  logic [63:0]           st2_i,
  input  logic [63:0]           st3_i,
  input  logic [RND_W+3:0]      rnd_i,
  input  logic                  rnd_valid_i,
  output logic                  rnd_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [63:0]           res1_o,
  output logic [63:0]           res2_o,
  output logic [63:0]           res3_o,
  output logic [NIB_W-1:0]      sb_in1_o,
  output logic [NIB_W-1:0]      sb_in2_o,
  output logic [NIB_W-1:0]      sb_in3_o,
  output logic [RND_W-1:0]      sb_r_o,
  output logic [KLMN_IN1_W-1:0] sb_klmn1_o,
  output logic [KLMN_IO_W-1:0]  sb_klmn2_o,
  input  logic [NIB_W-1:0]      sb_out1_i,
  input  logic [NIB_W-1:0]      sb_out2_i,
  input  logic [NIB_W-1:0]      sb_out3_i,
  input  logic [KLMN_IO_W-1:0]  sb_klmn_out_i
);
  layer_state_e           state;
  logic [3:0]             iss_idx;
  logic [3:0]             col_idx;
  logic [SBOX_LAT-1:0]    vpipe;
  logic [63:0]            sh1_q, sh2_q, sh3_q;
  logic [KLMN_IO_W-1:0]   klmn_q;
  logic [NIB_W-1:0]       nib1, nib2, nib3;
  logic                   issue;
  logic                   collect;

  assign issue      = rnd_valid_i & rnd_ready_o;
  assign collect    = vpipe[SBOX_LAT-1];
  assign sb_klmn2_o = klmn_q;

  prince_share_nibble_sel u_sel (
    .st1  (sh1_q),
    .st2  (sh2_q),
    .st3  (sh3_q),
    .idx  (iss_idx),
    .nib1 (nib1),
    .nib2 (nib2),
    .nib3 (nib3)
  );

  // Bubble cycles present all-zero S-box inputs so no stale share leaks out.
  always_comb begin
    sb_in1_o   = '0;
    sb_in2_o   = '0;
    sb_in3_o   = '0;
    sb_r_o     = '0;
    sb_klmn1_o = '0;
    if (issue) begin
      sb_in1_o   = nib1;
      sb_in2_o   = nib2;
      sb_in3_o   = nib3;
      sb_r_o     = rnd_i[RND_W-1:0];
      sb_klmn1_o = rnd_i[RND_W+3:RND_W];
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      iss_idx     <= '0;
      col_idx     <= '0;
      vpipe       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      sh3_q       <= '0;
      klmn_q      <= '0;
      res1_o      <= '0;
      res2_o      <= '0;
      res3_o      <= '0;
      rnd_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      // Shift toward the tail; the cast drops the bit that falls off the end.
      vpipe  <= SBOX_LAT'({vpipe, issue});

      if (issue) iss_idx <= iss_idx + 4'd1;

      if (collect) begin
        res1_o[col_idx*NIB_W +: NIB_W] <= sb_out1_i;
        res2_o[col_idx*NIB_W +: NIB_W] <= sb_out2_i;
        res3_o[col_idx*NIB_W +: NIB_W] <= sb_out3_i;
        klmn_q  <= sb_klmn_out_i;
        col_idx <= col_idx + 4'd1;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            sh1_q       <= st1_i;
            sh2_q       <= st2_i;
            sh3_q       <= st3_i;
            iss_idx     <= '0;
            col_idx     <= '0;
            klmn_q      <= '0;
            state       <= ISSUE;
            rnd_ready_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue && iss_idx == 4'(NIBBLES - 1)) begin
            state       <= DRAIN;
            rnd_ready_o <= 1'b0;
          end
        end
        DRAIN: begin
          if (collect && col_idx == 4'(NIBBLES - 1)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule
